counter_btn_ctrl: RTL

Command and counting stage that sits directly downstream of the button debouncers in the counter10000 design. It consumes the single-cycle debounced button pulses for run/stop, clear and mode. It runs a STOP/RUN/CLEAR state machine and a tick prescaler, and maintains the 0–9999 BCD-range count that feeds the FND display stage.

---
 rtl/counter_btn_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/counter_btn_ctrl.sv
// rtl/counter_btn_ctrl.sv - run/stop/clear FSM, tick prescaler and 0..MAX_COUNT counter
// Optional feature macro: COUNTER_BTN_CTRL_DOWN_EN (adds up/down mode; default build counts up only)
module counter_btn_ctrl #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run_stop,
    input  logic        i_clear,
    input  logic        i_mode,
    output logic [13:0] o_count,
    output logic        o_run,
    output logic        o_mode,
    output logic        o_tick
);

    localparam int                DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [13:0]       CNT_MAX  = 14'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DIV_W-1:0]   div;
    logic               tick;
    logic [13:0]        count;
    logic [13:0]        count_next;
    logic               mode;

    // A step happens on the last prescaler cycle while running
    assign tick = (state == ST_RUN) && (div == DIV_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; clear wins over run/stop in STOP, CLEAR lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_STOP: begin
                if (i_clear) begin
                    state_next = ST_CLEAR;
                end else if (i_run_stop) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_run_stop) begin
                    state_next = ST_STOP;
                end
            end
            ST_CLEAR: begin
                state_next = ST_STOP;
            end
            default: begin
                state_next = ST_STOP;
            end
        endcase
    end

    // Prescaler runs only in RUN so a resume always waits a full period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (state == ST_RUN) begin
            div <= tick ? '0 : div + DIV_ONE;
        end else begin
            div <= '0;
        end
    end

`ifdef COUNTER_BTN_CTRL_DOWN_EN
    // Direction toggle, accepted in every state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode <= 1'b0;
        end else if (i_mode) begin
            mode <= ~mode;
        end
    end

    // Next count value with explicit wrap in both directions
    always_comb begin
        count_next = count;
        if (mode) begin
            count_next = (count == 14'd0) ? CNT_MAX : count - 14'd1;
        end else begin
            count_next = (count >= CNT_MAX) ? 14'd0 : count + 14'd1;
        end
    end
`else
    logic mode_unused;
    assign mode_unused = i_mode;
    assign mode        = 1'b0;

    // Next count value, up only with explicit wrap
    always_comb begin
        count_next = count;
        count_next = (count >= CNT_MAX) ? 14'd0 : count + 14'd1;
    end
`endif

    // Count register: zeroed when leaving CLEAR, stepped on each tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 14'd0;
        end else if (state == ST_CLEAR) begin
            count <= 14'd0;
        end else if (tick) begin
            count <= count_next;
        end
    end

    // Tick output is registered so it lines up with the new count value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_tick <= 1'b0;
        end else begin
            o_tick <= tick;
        end
    end

    assign o_count = count;
    assign o_run   = (state == ST_RUN);
    assign o_mode  = mode;

endmodule
